// File: rtl/chroma_pkg.sv
// chroma_pkg: shared widths, default timing constants and FSM state type for the burst gate.
package chroma_pkg;
    localparam int ERR_W  = 12;
    localparam int ACC_W  = 20;
    localparam int LCNT_W = 12;
    localparam int CNT_W  = 5;
    localparam int BCNT_W = 7;
    localparam int BURST_START_DEF  = 60;
    localparam int BURST_LEN_DEF    = 40;
    localparam int MIN_LINE_DEF     = 1000;
    localparam int LINE_TIMEOUT_DEF = 4000;
    localparam int LOCK_THRESH_DEF  = 256;
    localparam int LOCK_LINES_DEF   = 16;
    localparam int UNLOCK_LINES_DEF = 4;
    typedef enum logic [2:0] {NOSYNC, WAIT_BURST, BURST, EVAL, LINE} burst_state_t;
    // Most-negative value folds to most-positive so the magnitude stays in ACC_W bits.
    function automatic logic [ACC_W-1:0] abs_sat(input logic signed [ACC_W-1:0] v);
        return !v[ACC_W-1] ? v : v == {1'b1, {(ACC_W-1){1'b0}}} ? {1'b0, {(ACC_W-1){1'b1}}} : -v;
    endfunction
endpackage

// File: rtl/burst_gate_ctrl_if.sv
// burst_gate_ctrl_if: sync separator / demodulator inputs and loop-filter control outputs.
interface burst_gate_ctrl_if;
    import chroma_pkg::*;
    logic                     hsync_n;
    logic signed [ERR_W-1:0]  error_in;
    logic                     burst_active;
    logic                     filter_rst;
    logic                     line_strobe;
    logic signed [ACC_W-1:0]  burst_err;
    logic                     locked;
    logic                     sync_lost;
    modport master (output hsync_n, error_in,
                    input  burst_active, filter_rst, line_strobe, burst_err, locked, sync_lost);
    modport slave  (input  hsync_n, error_in,
                    output burst_active, filter_rst, line_strobe, burst_err, locked, sync_lost);
endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser with a one-cycle falling-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_n_i,
    output logic fall_o
);
    logic [2:0] sh_q;
    // Resets to the idle-high level so release never looks like an edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) sh_q <= '1;
        else     sh_q <= {sh_q[1:0], async_n_i};
    assign fall_o = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/burst_gate_ctrl.sv
// burst_gate_ctrl: per-line burst window, sync-loss detection and PLL lock qualification.
module burst_gate_ctrl
    import chroma_pkg::*;
#(
    parameter int BURST_START  = BURST_START_DEF,
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int MIN_LINE     = MIN_LINE_DEF,
    parameter int LINE_TIMEOUT = LINE_TIMEOUT_DEF,
    parameter int LOCK_THRESH  = LOCK_THRESH_DEF,
    parameter int LOCK_LINES   = LOCK_LINES_DEF,
    parameter int UNLOCK_LINES = UNLOCK_LINES_DEF
) (
    input logic clk,
    input logic rst,
    burst_gate_ctrl_if.slave bus
);
    localparam logic [LCNT_W-1:0] START_M1 = LCNT_W'(BURST_START - 1);
    localparam logic [LCNT_W-1:0] MIN_C    = LCNT_W'(MIN_LINE);
    localparam logic [LCNT_W-1:0] TMO_C    = LCNT_W'(LINE_TIMEOUT);
    localparam logic [BCNT_W-1:0] LEN_M1   = BCNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  LOCK_C   = CNT_W'(LOCK_LINES);
    localparam logic [CNT_W-1:0]  UNLOCK_C = CNT_W'(UNLOCK_LINES);
    localparam logic [ACC_W-1:0]  THRESH_C = ACC_W'(LOCK_THRESH);

    burst_state_t            state_q;
    logic [LCNT_W-1:0]       line_cnt_q, line_cnt_d;
    logic [BCNT_W-1:0]       bcnt_q;
    logic signed [ACC_W-1:0] acc_q, sum_d, burst_err_q;
    logic [CNT_W-1:0]        good_q, bad_q, good_d, bad_d;
    logic                    edge_s, tmo, accept, good, lock_d;
    logic                    burst_active_q, filter_rst_q, sync_lost_q, line_strobe_q, locked_q;

    sync_edge_detect u_sync (.clk(clk), .rst(rst), .async_n_i(bus.hsync_n), .fall_o(edge_s));

    // Lock bookkeeping uses the sum including the final burst sample, so results land with the strobe.
    always_comb begin
        sum_d      = acc_q + {{(ACC_W-ERR_W){bus.error_in[ERR_W-1]}}, bus.error_in};
        good       = abs_sat(sum_d) < THRESH_C;
        good_d     = good ? (&good_q ? good_q : good_q + 1'b1) : '0;
        bad_d      = good ? '0 : (&bad_q ? bad_q : bad_q + 1'b1);
        lock_d     = good_d >= LOCK_C ? 1'b1 : bad_d >= UNLOCK_C ? 1'b0 : locked_q;
        tmo        = state_q != NOSYNC && line_cnt_q == TMO_C;
        accept     = edge_s && !tmo && (state_q == NOSYNC || (state_q == LINE && line_cnt_q >= MIN_C));
        line_cnt_d = accept ? '0 : &line_cnt_q ? line_cnt_q : line_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= NOSYNC;
            line_cnt_q     <= '0;
            bcnt_q         <= '0;
            acc_q          <= '0;
            good_q         <= '0;
            bad_q          <= '0;
            burst_err_q    <= '0;
            burst_active_q <= 1'b0;
            filter_rst_q   <= 1'b1;
            sync_lost_q    <= 1'b1;
            line_strobe_q  <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            line_cnt_q    <= line_cnt_d;
            line_strobe_q <= 1'b0;
            if (tmo) begin
                state_q        <= NOSYNC;
                acc_q          <= '0;
                good_q         <= '0;
                bad_q          <= '0;
                locked_q       <= 1'b0;
                burst_active_q <= 1'b0;
                filter_rst_q   <= 1'b1;
                sync_lost_q    <= 1'b1;
            end else begin
                case (state_q)
                    NOSYNC: if (accept) begin
                        state_q      <= WAIT_BURST;
                        filter_rst_q <= 1'b0;
                        sync_lost_q  <= 1'b0;
                    end
                    WAIT_BURST: if (line_cnt_q == START_M1) begin
                        state_q        <= BURST;
                        burst_active_q <= 1'b1;
                        bcnt_q         <= '0;
                    end
                    BURST: if (bcnt_q == LEN_M1) begin
                        state_q        <= EVAL;
                        burst_active_q <= 1'b0;
                        burst_err_q    <= sum_d;
                        acc_q          <= '0;
                        line_strobe_q  <= 1'b1;
                        good_q         <= good_d;
                        bad_q          <= bad_d;
                        locked_q       <= lock_d;
                    end else begin
                        acc_q  <= sum_d;
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                    EVAL: state_q <= LINE;
                    LINE: if (accept) state_q <= WAIT_BURST;
                    default: state_q <= NOSYNC;
                endcase
            end
        end
    end

    assign bus.burst_active = burst_active_q;
    assign bus.filter_rst   = filter_rst_q;
    assign bus.sync_lost    = sync_lost_q;
    assign bus.line_strobe  = line_strobe_q;
    assign bus.burst_err    = burst_err_q;
    assign bus.locked       = locked_q;
endmodule

// File: tb/tb_burst_gate_ctrl.sv
// tb_burst_gate_ctrl: directed lines with a queued scoreboard checked at each line strobe.
module tb_burst_gate_ctrl;
    import chroma_pkg::*;
    typedef struct { int start; int err; logic lk; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    burst_gate_ctrl_if bus ();
    burst_gate_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint act, longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_burst_active"}, bus.burst_active, 0);
        chk({tag, "_filter_rst"}, bus.filter_rst, 1);
        chk({tag, "_sync_lost"}, bus.sync_lost, 1);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_line_strobe"}, bus.line_strobe, 0);
        chk({tag, "_burst_err"}, bus.burst_err, 0);
    endtask

    // Edge detect lands at c0+2, so the window spans c0+63..c0+102; error_in is junk outside it.
    task automatic send_line(int e, int err, logic lk, bit chk_leave, bit eq, output int c0);
        c0 = cyc;
        bus.hsync_n = 1'b0;
        exp_q.push_back('{c0 + 63, err, lk});
        if (chk_leave) begin
            wait_until(c0 + 2);
            chk("filter_rst_at_E", bus.filter_rst, 1);
            chk("sync_lost_at_E", bus.sync_lost, 1);
            wait_until(c0 + 3);
            chk("filter_rst_at_E1", bus.filter_rst, 0);
            chk("sync_lost_at_E1", bus.sync_lost, 0);
        end
        wait_until(c0 + 4);
        bus.hsync_n = 1'b1;
        if (eq) begin
            wait_until(c0 + 30);
            bus.hsync_n = 1'b0;
            wait_until(c0 + 34);
            bus.hsync_n = 1'b1;
        end
        wait_until(c0 + 62);
        bus.error_in = 12'(e);
        wait_until(c0 + 103);
        bus.error_in = 12'sd777;
    endtask

    initial begin : monitor
        int   bstart;
        bit   in_b;
        exp_t x;
        bstart = -1000;
        in_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) in_b = 1'b0;
            else begin
                if (bus.burst_active && !in_b) begin
                    in_b = 1'b1;
                    bstart = cyc;
                end
                if (!bus.burst_active && in_b) begin
                    in_b = 1'b0;
                    chk("burst_width", cyc - bstart, 40);
                end
                if (bus.line_strobe) begin
                    if (exp_q.size() == 0) chk("unexpected_strobe", exp_q.size(), 1);
                    else begin
                        x = exp_q.pop_front();
                        chk("burst_start", bstart, x.start);
                        chk("strobe_cycle", cyc, bstart + 40);
                        chk("burst_err", bus.burst_err, x.err);
                        chk("locked", bus.locked, x.lk);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int c0;
        bus.hsync_n = 1'b1;
        bus.error_in = 12'sd777;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("in_reset");
        rst = 1'b0;
        wait_until(cyc + 5);
        chk_reset_vals("idle");
        for (int i = 0; i < 3; i++) begin
            send_line(3, 120, 1'b0, i == 0, 1'b0, c0);
            wait_until(c0 + 1500);
        end
        send_line(10, 400, 1'b0, 1'b0, 1'b0, c0);
        wait_until(c0 + 1500);
        for (int i = 0; i < 16; i++) begin
            send_line(0, 0, i == 15, 1'b0, 1'b0, c0);
            wait_until(c0 + 1500);
        end
        for (int i = 0; i < 4; i++) begin
            send_line(10, 400, i < 3, 1'b0, 1'b0, c0);
            wait_until(c0 + 1500);
        end
        // Line 5 gets equalising edges in WAIT_BURST and at +500; a cleared counter would reject the next line.
        for (int i = 0; i < 16; i++) begin
            send_line(0, 0, i == 15, 1'b0, i == 5, c0);
            if (i == 5) begin
                wait_until(c0 + 500);
                bus.hsync_n = 1'b0;
                wait_until(c0 + 504);
                bus.hsync_n = 1'b1;
            end
            if (i < 15) wait_until(c0 + 1500);
        end
        wait_until(c0 + 4003);
        chk("locked_before_loss", bus.locked, 1);
        chk("sync_lost_before_timeout", bus.sync_lost, 0);
        wait_until(c0 + 4004);
        chk("sync_lost_at_timeout", bus.sync_lost, 1);
        chk("filter_rst_at_timeout", bus.filter_rst, 1);
        chk("locked_at_timeout", bus.locked, 0);
        wait_until(c0 + 4100);
        send_line(-2048, -81920, 1'b0, 1'b1, 1'b0, c0);
        wait_until(c0 + 1500);
        c0 = cyc;
        bus.hsync_n = 1'b0;
        wait_until(c0 + 4);
        bus.hsync_n = 1'b1;
        bus.error_in = 12'sd5;
        wait_until(c0 + 80);
        chk("mid_burst_active", bus.burst_active, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        bus.error_in = 12'sd777;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_until(cyc + 10);
        send_line(3, 120, 1'b0, 1'b1, 1'b0, c0);
        wait_until(c0 + 1500);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
